// File: rtl/scan_pkg.sv
// Shared types and default timing constants for the digit scan controller.
//   scan_state_t      : controller state encoding (IDLE, BLANK, SHOW)
//   SCAN_SLOT_CYCLES  : default clocks per digit slot (1 kHz/digit at 100 MHz)
//   SCAN_BLANK_CYCLES : default leading blank clocks of each slot
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  localparam int unsigned SCAN_SLOT_CYCLES  = 100000;
  localparam int unsigned SCAN_BLANK_CYCLES = 1000;

endpackage

// File: rtl/slot_counter.sv
// Modulo-N up-counter with synchronous clear, count enable and terminal-count
// flag.
//   clk : clock, rising edge
//   clr : synchronous clear to 0 (wins over inc)
//   inc : count enable; wraps N-1 -> 0
//   cnt : current count
//   tc  : high while cnt == N-1
module slot_counter #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         tc
);

  assign tc = (cnt == W'(N - 1));

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= tc ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexing controller for a 4-digit display. Drives the select and
// enable of the downstream 2-to-4 decoder, stepping through digits 0..3 with a
// blanking interval at the start of every slot and a per-digit enable mask.
//   clk        : system clock, rising edge
//   rst        : synchronous reset, active-high
//   run        : scan enable; 0 freezes sel and blanks the display
//   digit_mask : bit i enables digit i
//   sel        : current digit index (decoder in)
//   en         : decoder enable
//   slot_tick  : one-cycle pulse on every digit advance
module digit_scan_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned SLOT_CYCLES  = SCAN_SLOT_CYCLES,
  parameter int unsigned BLANK_CYCLES = SCAN_BLANK_CYCLES,
  parameter int unsigned CNT_W        = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [3:0] digit_mask,
  output logic [1:0] sel,
  output logic       en,
  output logic       slot_tick
);

  scan_state_t      state_q, state_d;
  logic [1:0]       sel_d;
  logic [1:0]       sel_inc;
  logic             en_d;
  logic             tick_d;
  logic [CNT_W-1:0] cnt;
  logic             slot_end;
  logic             cnt_clr;
  logic             blank_done;

  // Counter sits at 0 while idle or stopped so a restart gets a fresh slot.
  assign cnt_clr = rst | ~run | (state_q == IDLE);

  slot_counter #(
    .N (SLOT_CYCLES),
    .W (CNT_W)
  ) u_slot_counter (
    .clk (clk),
    .clr (cnt_clr),
    .inc (1'b1),
    .cnt (cnt),
    .tc  (slot_end)
  );

  assign blank_done = (cnt == CNT_W'(BLANK_CYCLES - 1));
  assign sel_inc    = sel + 2'd1;

  // en is loaded for the state being entered, so a slot shows exactly
  // BLANK_CYCLES clocks of en=0 followed by SLOT_CYCLES-BLANK_CYCLES of mask.
  always_comb begin
    state_d = state_q;
    sel_d   = sel;
    en_d    = 1'b0;
    tick_d  = 1'b0;
    if (!run) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (BLANK_CYCLES == 0) begin
            state_d = SHOW;
            en_d    = digit_mask[sel];
          end else begin
            state_d = BLANK;
          end
        end
        BLANK: begin
          if (blank_done) begin
            state_d = SHOW;
            en_d    = digit_mask[sel];
          end
        end
        SHOW: begin
          en_d = digit_mask[sel];
          if (slot_end) begin
            sel_d  = sel_inc;
            tick_d = 1'b1;
            if (BLANK_CYCLES == 0) begin
              en_d = digit_mask[sel_inc];
            end else begin
              state_d = BLANK;
              en_d    = 1'b0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sel       <= '0;
      en        <= 1'b0;
      slot_tick <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel       <= sel_d;
      en        <= en_d;
      slot_tick <= tick_d;
    end
  end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed self-checking bench for digit_scan_ctrl with SLOT_CYCLES=8,
// BLANK_CYCLES=2. Expected outputs come from the slot timing: k counts clocks
// since the edge that started scanning; slot = k/8, position c = k%8,
// sel = start_sel + slot, en = (c >= 2) & mask[sel], tick on c==0 after slot 0.
module tb_digit_scan_ctrl;

  localparam int unsigned SLOT  = 8;
  localparam int unsigned BLANK = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [3:0] digit_mask;
  logic [1:0] sel;
  logic       en;
  logic       slot_tick;

  int         n_cmp = 0;
  int         n_err = 0;
  int         k;
  logic [1:0] ref_sel;

  always #5 clk = ~clk;

  digit_scan_ctrl #(
    .SLOT_CYCLES  (SLOT),
    .BLANK_CYCLES (BLANK),
    .CNT_W        (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .digit_mask (digit_mask),
    .sel        (sel),
    .en         (en),
    .slot_tick  (slot_tick)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [1:0] exp_sel,
                       input logic exp_en, input logic exp_tick);
    n_cmp++;
    assert (sel === exp_sel) else begin
      n_err++;
      $error("FAIL %s sel: got %0d expected %0d", tag, sel, exp_sel);
    end
    n_cmp++;
    assert (en === exp_en) else begin
      n_err++;
      $error("FAIL %s en: got %0b expected %0b", tag, en, exp_en);
    end
    n_cmp++;
    assert (slot_tick === exp_tick) else begin
      n_err++;
      $error("FAIL %s slot_tick: got %0b expected %0b", tag, slot_tick, exp_tick);
    end
  endtask

  // Advance n clocks while scanning, checking each against the slot timing.
  task automatic scan(input string tag, input int n);
    int         c;
    logic [1:0] exp_sel;
    logic       exp_en;
    logic       exp_tick;
    for (int i = 0; i < n; i++) begin
      step();
      c        = k % SLOT;
      exp_sel  = ref_sel + 2'(k / SLOT);
      exp_en   = (c >= BLANK) && digit_mask[exp_sel];
      exp_tick = (k >= SLOT) && (c == 0);
      check(tag, exp_sel, exp_en, exp_tick);
      k++;
    end
  endtask

  initial begin
    rst        = 1'b1;
    run        = 1'b1;
    digit_mask = 4'b1111;
    k          = 0;
    ref_sel    = 2'd0;

    // Reset held for 3 clocks
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset", 2'd0, 1'b0, 1'b0);
    end

    // Full scan with all digits enabled, including the 3->0 wrap
    rst     = 1'b0;
    k       = 0;
    ref_sel = 2'd0;
    scan("full_scan", 40);

    // Mask 0101 over a full 32-clock scan, then on to slot 0 mid-SHOW
    digit_mask = 4'b0101;
    scan("mask_scan", 32);
    scan("mask_pre_toggle", 28);        // last observed k=99: sel 0, c=3

    // Toggle mask bit 0 mid-SHOW; en follows one clock later
    digit_mask = 4'b0100;
    scan("mask_toggle_off", 2);
    digit_mask = 4'b0101;
    scan("mask_toggle_on", 2);

    // Walk to cnt=5 in the sel=2 slot (k=117)
    scan("to_stop_mid", 14);

    // Stop mid-slot: en drops next clock, sel holds
    run = 1'b0;
    step();
    check("stop_mid", 2'd2, 1'b0, 1'b0);
    step();
    check("stop_mid_hold", 2'd2, 1'b0, 1'b0);

    // Restart resumes at sel=2 with a full slot, then runs to cnt=7 of sel=3
    run     = 1'b1;
    k       = 0;
    ref_sel = 2'd2;
    scan("restart", 16);

    // Stop on the slot-end cycle: no advance, no tick
    run = 1'b0;
    step();
    check("stop_slot_end", 2'd3, 1'b0, 1'b0);
    step();
    check("stop_slot_end_hold", 2'd3, 1'b0, 1'b0);

    // Restart at sel=3, reach SHOW, then reset mid-operation
    run     = 1'b1;
    k       = 0;
    ref_sel = 2'd3;
    scan("restart_sel3", 5);
    rst = 1'b1;
    step();
    check("reset_mid", 2'd0, 1'b0, 1'b0);
    step();
    check("reset_mid_hold", 2'd0, 1'b0, 1'b0);

    // Release with run=1: normal start from sel=0
    rst     = 1'b0;
    k       = 0;
    ref_sel = 2'd0;
    scan("post_reset", 12);

    // All-zero mask: scanning continues, en stays low
    digit_mask = 4'b0000;
    scan("mask_zero", 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
